// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives the synchronous
//               instruction memory and fills the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_out,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             flush_id_ex,
  output logic             fetch_fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_pend_valid;
  logic [31:0]      r_pend_pc;
  logic             r_if_id_valid;
  logic [31:0]      r_if_id_pc;
  logic [31:0]      r_if_id_pc_plus4;
  logic [31:0]      r_if_id_instr;
  logic             r_fault;
  logic [31:0]      r_fault_addr;
  logic [CNT_W-1:0] r_redirect_count;

  logic             w_run;
  logic             w_take_branch;
  logic             w_take_jump;
  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_misaligned;

  // EX is older than ID, so a branch outranks a jump; a stall only holds back jumps.
  assign w_run         = (r_state == ST_RUN);
  assign w_take_branch = w_run & branch_out;
  assign w_take_jump   = w_run & jump & ~stall & ~branch_out;
  assign w_redirect    = w_take_branch | w_take_jump;
  assign w_target      = branch_out ? {branch_target[31:1], 1'b0}
                                    : {jump_target[31:1], 1'b0};
  assign w_misaligned  = w_target[1];

  assign imem_req       = w_run;
  assign imem_addr      = (stall && r_pend_valid) ? r_pend_pc : r_pc;
  assign flush_id_ex    = w_take_branch;
  assign if_id_valid    = r_if_id_valid;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_instr    = r_if_id_instr;
  assign fetch_fault    = r_fault;
  assign fault_addr     = r_fault_addr;
  assign redirect_count = r_redirect_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= ST_RUN;
      r_pc             <= RESET_PC;
      r_pend_valid     <= 1'b0;
      r_pend_pc        <= 32'h0;
      r_if_id_valid    <= 1'b0;
      r_if_id_pc       <= 32'h0;
      r_if_id_pc_plus4 <= 32'h4;
      r_if_id_instr    <= NOP;
      r_fault          <= 1'b0;
      r_fault_addr     <= 32'h0;
      r_redirect_count <= '0;
    end else if (r_state == ST_HALT) begin
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= NOP;
      r_pend_valid  <= 1'b0;
    end else if (w_redirect) begin
      r_pend_valid  <= 1'b0;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= NOP;
      if (w_misaligned) begin
        r_state      <= ST_HALT;
        r_fault      <= 1'b1;
        r_fault_addr <= w_target;
      end else begin
        r_pc             <= w_target;
        r_redirect_count <= r_redirect_count + CNT_W'(1);
      end
    end else if (!stall) begin
      r_pc         <= r_pc + 32'd4;
      r_pend_valid <= 1'b1;
      r_pend_pc    <= r_pc;
      if (r_pend_valid) begin
        r_if_id_valid    <= 1'b1;
        r_if_id_pc       <= r_pend_pc;
        r_if_id_pc_plus4 <= r_pend_pc + 32'd4;
        r_if_id_instr    <= imem_rdata;
      end else begin
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core. It owns the PC and issues requests to the synchronous-read instruction memory, and it fills the IF/ID pipeline register. It consumes the taken-branch decision from the branch decoder in EX and jump targets from ID, squashing wrong-path fetches on every redirect. It also stalls with the hazard unit and halts on a misaligned redirect target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, value driven on if_id_instr while if_id_valid=0
- CNT_W, 16, width of the redirect counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset: one clock; reset is synchronous and active-low
- stall  in  1  hazard-unit stall of IF and ID
- branch_out  in  1  taken branch resolved in EX (branch decoder output)
- branch_target  in  32  branch destination
- jump  in  1  JAL/JALR resolved in ID
- jump_target  in  32  jump destination
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  fetch address; data returns on imem_rdata next cycle
- imem_rdata  in  32  instruction for the previous cycle's imem_addr
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_pc_plus4  out  32  if_id_pc + 4
- if_id_instr  out  32  instruction, NOP when invalid
- flush_id_ex  out  1  combinational; bubble ID/EX this cycle
- fetch_fault  out  1  sticky misaligned-target fault
- fault_addr  out  32  offending target
- redirect_count  out  CNT_W  accepted redirects, wraps modulo 2^CNT_W

## Operation
State:
- pc: address to request.
- pend_valid / pend_pc: a request was issued last cycle and its data is on imem_rdata now.
- IF/ID register.
- FSM: RUN or HALT.

Reset (reset_n=0 at an edge):
- pc=RESET_PC, pend_valid=0, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4, if_id_instr=NOP.
- fetch_fault=0, fault_addr=0, redirect_count=0, state=RUN.
- Reset applied mid-operation discards everything in flight.

RUN, no redirect, stall=0:
- imem_req=1, imem_addr=pc; pc<=pc+4 (wraps at 2^32).
- pend_valid<=1, pend_pc<=pc.
- If pend_valid, IF/ID<={pend_pc, imem_rdata}, valid=1; else valid<=0.

RUN, stall=1, no branch:
- imem_req=1 and imem_addr=pend_pc when pend_valid (re-request), otherwise pc.
- pc, pend state and IF/ID hold; the data arriving this cycle is dropped.
- jump is ignored while stall=1.

Redirect selection:
- branch_out=1 wins over jump (EX is older); stall does not block a branch.
- Effective target = target with bit0 forced to 0.

Aligned redirect (target[1]=0):
- pc<=target, pend_valid<=0, if_id_valid<=0, redirect_count++.
- Wrong-path request issued this cycle is discarded.
- flush_id_ex=1 only for a branch redirect.

Misaligned redirect (target[1]=1):
- state<=HALT, fetch_fault<=1, fault_addr<=target with bit0 cleared.
- if_id_valid<=0, pend_valid<=0; counter not incremented; flush_id_ex=1 if branch.

HALT:
- imem_req=0, if_id_valid=0, all inputs ignored.
- Exit only via reset.

## Timing
- Reset release cycle C0: imem_addr=RESET_PC. C1: RESET_PC+4. C2: if_id_valid=1, if_id_pc=RESET_PC.
- Fetch-to-IF/ID latency is 2 cycles; throughput is 1 instr/cycle without stall.
- Branch at cycle N:
  - flush_id_ex=1 in N.
  - if_id_valid=0 in N+1 and N+2.
  - imem_addr=target in N+1.
  - if_id_pc=target with valid in N+3.
  - Penalty is 2 fetch slots plus the flushed ID instruction.
- Back-to-back redirects: each one restarts the sequence; the last one wins.
- Stall release: IF/ID updates at the first edge with stall=0, using the re-fetched data.

## Test plan
- Reset, RESET_PC=0x100, imem returns addr^0xA5A5_0000 -> imem_addr 0x100,0x104,...; if_id_pc 0x100 at C2, then +4 each cycle with matching instr.
- Stall held 3 cycles while if_id_pc=0x108 -> IF/ID holds 0x108/its instr; after release, 0x10C follows with no gap or duplicate.
- branch_out=1, target 0x200 at N -> flush_id_ex=1 at N; valid low N+1..N+2; if_id_pc=0x200 at N+3; redirect_count=1.
- branch_out=1 (0x300) and jump=1 (0x400) same cycle, stall=1 -> fetch resumes at 0x300; count +1.
- jump to 0x402 -> fetch_fault=1, fault_addr=0x402, imem_req=0 thereafter; later branch ignored; reset_n=0 clears all outputs.
- jump to 0x501 -> fetch resumes at 0x500, no fault; 2^CNT_W redirects wrap counter to 0.
